fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 106 ++++++++++
 tb/tb_fifo_stream_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Pops words from a registered-read FIFO and presents them as a valid/ready
// stream through a 2-entry skid buffer, counting delivered words.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   drain_Enable,
  input  logic                   sig_Empty,
  input  logic [DATA_WIDTH-1:0]  fifo_Data,
  output logic                   read_Enable,
  output logic                   out_Valid,
  input  logic                   out_Ready,
  output logic [DATA_WIDTH-1:0]  out_Data,
  output logic [COUNT_WIDTH-1:0] words_Read,
  output logic                   busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t            state, state_next;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] tail_data;
  logic [1:0]            occupancy;
  logic [1:0]            occ_after;
  logic [2:0]            committed;
  logic                  transfer;
  logic                  capture;

  assign transfer = out_Valid & out_Ready;
  assign capture  = inflight;

  // Words already owned after this cycle's transfer; a pop is only issued if
  // its word is guaranteed a free slot when it arrives next cycle.
  assign occ_after   = occupancy - {1'b0, transfer};
  assign committed   = {1'b0, occ_after} + {2'b00, inflight};
  assign read_Enable = ~reset & drain_Enable & ~sig_Empty & (committed < 3'd2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (capture) state_next = ONE;
      ONE: begin
        if (capture && !transfer)      state_next = TWO;
        else if (transfer && !capture) state_next = EMPTY;
      end
      TWO:     if (transfer) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    out_Valid = 1'b0;
    occupancy = 2'd0;
    case (state)
      ONE:     begin out_Valid = 1'b1; occupancy = 2'd1; end
      TWO:     begin out_Valid = 1'b1; occupancy = 2'd2; end
      default: begin out_Valid = 1'b0; occupancy = 2'd0; end
    endcase
  end

  assign busy = inflight | (state != EMPTY);

  // NOTE: the two buffer slots are reset as well, so out_Data reads zero out of
  // reset; with only two entries this costs nothing worth avoiding.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight  <= 1'b0;
      out_Data  <= '0;
      tail_data <= '0;
    end else begin
      inflight <= read_Enable;
      case (state)
        EMPTY: if (capture) out_Data <= fifo_Data;
        ONE: begin
          if (capture && transfer) out_Data  <= fifo_Data;
          else if (capture)        tail_data <= fifo_Data;
        end
        TWO:     if (transfer) out_Data <= tail_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      words_Read <= '0;
    else if (transfer && (words_Read != {COUNT_WIDTH{1'b1}}))
      words_Read <= words_Read + 1'b1;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader, checked against a
// queue-based model of the FIFO, the in-transit words and the stream.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          drain_Enable = 1'b0;
  logic          sig_Empty = 1'b1;
  logic [DW-1:0] fifo_Data = '0;
  logic          read_Enable;
  logic          out_Valid;
  logic          out_Ready = 1'b0;
  logic [DW-1:0] out_Data;
  logic [CW-1:0] words_Read;
  logic          busy;

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .drain_Enable (drain_Enable),
    .sig_Empty    (sig_Empty),
    .fifo_Data    (fifo_Data),
    .read_Enable  (read_Enable),
    .out_Valid    (out_Valid),
    .out_Ready    (out_Ready),
    .out_Data     (out_Data),
    .words_Read   (words_Read),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: FIFO contents, words popped but not yet delivered (in pop order),
  // whether the newest of those was popped last cycle, and delivery count.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] owed_q[$];
  bit            popped_last = 0;
  int            delivered = 0;
  int            pops = 0;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic cycle();
    bit exp_valid, exp_xfer, exp_re, pop;
    int pending;
    sig_Empty = (fifo_q.size() == 0);
    @(negedge clock);
    pending   = owed_q.size();
    exp_valid = (pending - int'(popped_last)) > 0;
    exp_xfer  = exp_valid && out_Ready;
    exp_re    = !reset && drain_Enable && !sig_Empty && ((pending - int'(exp_xfer)) < 2);
    check("out_valid", out_Valid, exp_valid);
    check("busy", busy, pending > 0);
    check("read_enable", read_Enable, exp_re);
    check("words_read", words_Read, (delivered > SAT) ? SAT : delivered);
    if (prev_hold) check("hold_data", out_Data, prev_data);
    if (exp_xfer && exp_valid) check("stream_data", out_Data, owed_q[0]);
    pop       = exp_re;
    prev_hold = exp_valid && !out_Ready && !reset;
    prev_data = out_Data;
    @(posedge clock);
    #1;
    if (reset) begin
      owed_q.delete();
      popped_last = 0;
      delivered   = 0;
      prev_hold   = 0;
      fifo_Data   = DW'($urandom);
    end else begin
      if (exp_xfer) begin
        void'(owed_q.pop_front());
        delivered++;
      end
      popped_last = pop;
      if (pop) begin
        fifo_Data = fifo_q.pop_front();
        owed_q.push_back(fifo_Data);
        pops++;
      end else begin
        fifo_Data = DW'($urandom);
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drain_Enable = 1'b0;
    out_Ready = 1'b0;
    fifo_q.delete();
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    #1;
    do_reset(2);
    check("reset_data", out_Data, 0);
    check("reset_valid", out_Valid, 0);

    // Basic drain of three words.
    fifo_q = '{8'h11, 8'h22, 8'h33};
    drain_Enable = 1'b1;
    out_Ready = 1'b1;
    run(8);
    check("basic_count", words_Read, 3);
    check("basic_busy", busy, 0);

    // Backpressure: only two pops may be issued while stalled.
    do_reset(1);
    fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    pops = 0;
    drain_Enable = 1'b1;
    run(6);
    check("bp_pops", pops, 2);
    check("bp_head", out_Data, 8'hA0);
    out_Ready = 1'b1;
    run(10);
    check("bp_count", words_Read, 5);

    // Empty FIFO: nothing is ever popped.
    do_reset(1);
    drain_Enable = 1'b1;
    out_Ready = 1'b1;
    pops = 0;
    run(10);
    check("empty_pops", pops, 0);

    // Drain disabled right after one pop.
    do_reset(1);
    fifo_q = '{8'h51, 8'h52, 8'h53, 8'h54};
    pops = 0;
    out_Ready = 1'b1;
    drain_Enable = 1'b1;
    run(1);
    drain_Enable = 1'b0;
    run(6);
    check("disable_pops", pops, 1);
    check("disable_count", words_Read, 1);
    check("disable_remaining", fifo_q.size(), 3);

    // Reset while holding two words with nothing in flight.
    do_reset(1);
    fifo_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    drain_Enable = 1'b1;
    run(4);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    drain_Enable = 1'b0;
    run(1);
    check("post_reset_valid", out_Valid, 0);
    check("post_reset_count", words_Read, 0);

    // Saturation of the narrow counter.
    do_reset(1);
    for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(i + 1));
    drain_Enable = 1'b1;
    out_Ready = 1'b1;
    run(30);
    check("sat_count", words_Read, SAT);

    // Random traffic with occasional resets.
    do_reset(1);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) fifo_q.push_back(DW'($urandom));
      drain_Enable = ($urandom_range(0, 4) != 0);
      out_Ready    = ($urandom_range(0, 2) != 0);
      reset        = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
